// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-style controller: opcodes, FSM states,
// PC source encodings and the packed control/class payloads.
package mips_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned CNT_W   = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_LT   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd5;
  localparam logic [OP_W-1:0] OP_ST   = 4'd6;
  localparam logic [OP_W-1:0] OP_LD   = 4'd7;
  localparam logic [OP_W-1:0] OP_SLI  = 4'd8;
  localparam logic [OP_W-1:0] OP_BR   = 4'd9;
  localparam logic [OP_W-1:0] OP_JUMP = 4'd10;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ = 2'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_BR  = 2'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_JMP = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef struct packed {
    logic rtype;
    logic ld;
    logic st;
    logic sli;
    logic br;
    logic jump;
    logic illegal;
  } op_class_t;

  typedef struct packed {
    logic               mem_req;
    logic               iord;
    logic               ir_write;
    logic               pc_en;
    logic [PCSRC_W-1:0] pc_src;
    logic               reg_wr;
    logic               reg_des;
    logic               alu_src;
    logic               mem2reg;
    logic               mem_rd;
    logic               mem_wr;
    logic               sti;
    logic               illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_ctrl_if;
  import mips_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               iord;
  logic               ir_write;
  logic               pc_en;
  logic [PCSRC_W-1:0] pc_src;
  logic               reg_wr;
  logic               reg_des;
  logic               alu_src;
  logic               mem2reg;
  logic               mem_rd;
  logic               mem_wr;
  logic               sti;
  logic               illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, iord, ir_write, pc_en, pc_src,
           reg_wr, reg_des, alu_src, mem2reg, mem_rd, mem_wr, sti, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, iord, ir_write, pc_en, pc_src,
           reg_wr, reg_des, alu_src, mem2reg, mem_rd, mem_wr, sti, illegal
  );

endinterface

// File: rtl/multicycle_decode.sv
// Combinational opcode -> instruction-class flags.
module multicycle_decode
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_ADD, OP_SUB, OP_LT, OP_OR, OP_AND, OP_SHL: cls.rtype = 1'b1;
      OP_ST:   cls.st      = 1'b1;
      OP_LD:   cls.ld      = 1'b1;
      OP_SLI:  cls.sli     = 1'b1;
      OP_BR:   cls.br      = 1'b1;
      OP_JUMP: cls.jump    = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with shared req/ready memory port.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle and retired-instruction counters.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] dec_op;
  op_class_t       cls;
  ctrl_t           ctl, ctl_o;

  // op_q is not yet loaded during DECODE, so classify the live IR field there
  assign dec_op = (state_q == S_DECODE) ? bus.opcode : op_q;

  multicycle_decode u_decode (
    .op  (dec_op),
    .cls (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        ctl.mem_rd  = 1'b1;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_en    = 1'b1;
          ctl.pc_src   = PCSRC_SEQ;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls.jump) begin
          ctl.pc_en  = 1'b1;
          ctl.pc_src = PCSRC_JMP;
          state_d    = S_FETCH;
        end else if (cls.illegal) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ctl.alu_src = cls.ld | cls.st | cls.sli;
        if (cls.br) begin
          ctl.pc_en  = bus.zero;
          ctl.pc_src = PCSRC_BR;
          state_d    = S_FETCH;
        end else if (cls.ld || cls.st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        ctl.alu_src = 1'b1;
        ctl.mem_rd  = cls.ld;
        ctl.mem_wr  = cls.st;
        if (bus.mem_ready) state_d = cls.ld ? S_WB : S_FETCH;
      end
      S_WB: begin
        ctl.reg_wr  = 1'b1;
        ctl.reg_des = cls.rtype;
        ctl.mem2reg = cls.ld;
        ctl.sti     = cls.sli;
        ctl.alu_src = cls.sli;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        ctl.illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe at once so an in-flight access is abandoned immediately
  always_comb ctl_o = rst_n ? ctl : '0;

  assign bus.mem_req  = ctl_o.mem_req;
  assign bus.iord     = ctl_o.iord;
  assign bus.ir_write = ctl_o.ir_write;
  assign bus.pc_en    = ctl_o.pc_en;
  assign bus.pc_src   = ctl_o.pc_src;
  assign bus.reg_wr   = ctl_o.reg_wr;
  assign bus.reg_des  = ctl_o.reg_des;
  assign bus.alu_src  = ctl_o.alu_src;
  assign bus.mem2reg  = ctl_o.mem2reg;
  assign bus.mem_rd   = ctl_o.mem_rd;
  assign bus.mem_wr   = ctl_o.mem_wr;
  assign bus.sti      = ctl_o.sti;
  assign bus.illegal  = ctl_o.illegal;

`ifdef MULTICYCLE_CTRL_PERF_EN
  // An instruction retires whenever the FSM re-enters FETCH from elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state_d == S_FETCH && state_q != S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle check of multicycle_ctrl strobes; counters checked when
// MULTICYCLE_CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  // {mem_req, iord, ir_write, pc_en, pc_src[1:0], reg_wr, reg_des, alu_src, mem2reg, mem_rd, mem_wr, sti, illegal}
  localparam logic [13:0] MREQ    = 14'h2000;
  localparam logic [13:0] IORD    = 14'h1000;
  localparam logic [13:0] IRW     = 14'h0800;
  localparam logic [13:0] PCE     = 14'h0400;
  localparam logic [13:0] PCS_JMP = 14'h0200;
  localparam logic [13:0] PCS_BR  = 14'h0100;
  localparam logic [13:0] RW      = 14'h0080;
  localparam logic [13:0] RD      = 14'h0040;
  localparam logic [13:0] AS      = 14'h0020;
  localparam logic [13:0] M2R     = 14'h0010;
  localparam logic [13:0] MRD     = 14'h0008;
  localparam logic [13:0] MWR     = 14'h0004;
  localparam logic [13:0] STI     = 14'h0002;
  localparam logic [13:0] ILL     = 14'h0001;
  localparam logic [13:0] F_WAIT  = MREQ | MRD;
  localparam logic [13:0] F_GO    = MREQ | MRD | IRW | PCE;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [13:0] obs;

  multicycle_ctrl_if bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  assign obs = {bus.mem_req, bus.iord, bus.ir_write, bus.pc_en, bus.pc_src,
                bus.reg_wr, bus.reg_des, bus.alu_src, bus.mem2reg,
                bus.mem_rd, bus.mem_wr, bus.sti, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [13:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic [13:0] exp);
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.opcode    = OP_ADD;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_hold", 14'h0000);
    rst_n = 1'b1;
    cyc("fetch_idle", F_WAIT);

    // add, zero-wait memory: 4 cycles
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_ADD;
    cyc("add_f", F_GO);
    cyc("add_d", 14'h0000);
    cyc("add_e", 14'h0000);
    cyc("add_w", RW | RD);

    // sli: 4 cycles
    bus.opcode = OP_SLI;
    cyc("sli_f", F_GO);
    cyc("sli_d", 14'h0000);
    cyc("sli_e", AS);
    cyc("sli_w", RW | STI | AS);

    // ld with two wait states in MEM: 7 cycles
    bus.opcode = OP_LD;
    cyc("ld_f", F_GO);
    cyc("ld_d", 14'h0000);
    cyc("ld_e", AS);
    bus.mem_ready = 1'b0;
    cyc("ld_m0", MREQ | IORD | AS | MRD);
    cyc("ld_m1", MREQ | IORD | AS | MRD);
    bus.mem_ready = 1'b1;
    cyc("ld_m2", MREQ | IORD | AS | MRD);
    cyc("ld_w", RW | M2R);

    // br taken; mem_ready low in DECODE must be ignored
    bus.opcode = OP_BR;
    bus.zero   = 1'b1;
    cyc("brt_f", F_GO);
    bus.mem_ready = 1'b0;
    cyc("brt_d", 14'h0000);
    bus.mem_ready = 1'b1;
    cyc("brt_e", PCE | PCS_BR);

    // br not taken
    bus.zero = 1'b0;
    cyc("brn_f", F_GO);
    cyc("brn_d", 14'h0000);
    cyc("brn_e", PCS_BR);

    // jump with one fetch wait state
    bus.opcode    = OP_JUMP;
    bus.mem_ready = 1'b0;
    cyc("jmp_fwait", F_WAIT);
    bus.mem_ready = 1'b1;
    cyc("jmp_f", F_GO);
    cyc("jmp_d", PCE | PCS_JMP);

    // st, then reset asserted mid-MEM
    bus.opcode = OP_ST;
    cyc("st_f", F_GO);
    cyc("st_d", 14'h0000);
    cyc("st_e", AS);
    bus.mem_ready = 1'b0;
    cyc("st_m0", MREQ | IORD | AS | MWR);
    #2;
    chk("st_m1", MREQ | IORD | AS | MWR);
    rst_n = 1'b0;
    #1;
    chk("st_rst_async", 14'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("st_rst_fetch", F_WAIT);

    // illegal opcode: trap holds for 10 cycles regardless of mem_ready
    bus.mem_ready = 1'b1;
    bus.opcode    = 4'd13;
    cyc("ill_f", F_GO);
    cyc("ill_d", 14'h0000);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = 1'(i % 2);
      cyc("trap_hold", ILL);
    end
    rst_n = 1'b0;
    #1;
    chk("trap_rst", 14'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    cyc("trap_exit", F_WAIT);

    // add, st, br back to back after reset
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_ADD;
    cyc("p_add_f", F_GO);
    cyc("p_add_d", 14'h0000);
    cyc("p_add_e", 14'h0000);
    cyc("p_add_w", RW | RD);
    bus.opcode = OP_ST;
    cyc("p_st_f", F_GO);
    cyc("p_st_d", 14'h0000);
    cyc("p_st_e", AS);
    cyc("p_st_m", MREQ | IORD | AS | MWR);
    bus.opcode = OP_BR;
    bus.zero   = 1'b0;
    cyc("p_br_f", F_GO);
    cyc("p_br_d", 14'h0000);
    cyc("p_br_e", PCS_BR);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("p_back_fetch", F_WAIT);
`ifdef MULTICYCLE_CTRL_PERF_EN
    // 1 stalled fetch + 4 + 4 + 3 cycles since release; 3 instructions retired
    tests++;
    assert (instr_cnt === 32'd3) else begin
      fails++;
      $error("FAIL instr_cnt: observed %0d expected %0d", instr_cnt, 3);
    end
    tests++;
    assert (cycle_cnt === 32'd12) else begin
      fails++;
      $error("FAIL cycle_cnt: observed %0d expected %0d", cycle_cnt, 12);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
